// File: rtl/scl_ctrl_if.sv
// Scaler sequencer bus: sync/enable inputs, frame configuration, and the
// shadowed configuration, delayed timing and line-length status outputs.
interface scl_ctrl_if #(
    parameter int LINE_W = 12
);
    logic              scl_i_vsync;
    logic              scl_i_hsync;
    logic              scl_i_data_en;
    logic              scl_cfg_mode;
    logic              scl_cfg_rsz;
    logic [1:0]        scl_cfg_flt;
    logic              act_mode;
    logic              act_rsz;
    logic [1:0]        act_flt;
    logic              cfg_upd;
    logic              dp_en_d;
    logic              scl_o_data_en;
    logic              scl_o_hsync;
    logic              scl_o_vsync;
    logic [LINE_W-1:0] line_in_cnt;
    logic [LINE_W-1:0] line_out_cnt;
    logic              err_len;

    // Video source / controller side
    modport master (
        output scl_i_vsync, scl_i_hsync, scl_i_data_en,
        output scl_cfg_mode, scl_cfg_rsz, scl_cfg_flt,
        input  act_mode, act_rsz, act_flt, cfg_upd, dp_en_d,
        input  scl_o_data_en, scl_o_hsync, scl_o_vsync,
        input  line_in_cnt, line_out_cnt, err_len
    );

    // Sequencer side
    modport slave (
        input  scl_i_vsync, scl_i_hsync, scl_i_data_en,
        input  scl_cfg_mode, scl_cfg_rsz, scl_cfg_flt,
        output act_mode, act_rsz, act_flt, cfg_upd, dp_en_d,
        output scl_o_data_en, scl_o_hsync, scl_o_vsync,
        output line_in_cnt, line_out_cnt, err_len
    );
endinterface

// File: rtl/scl_ctrl.sv
// Frame/line sequencer for the RGB horizontal scaler: per-frame config
// shadowing, datapath-latency matching of enable and syncs, decimation
// keep pattern, and input/output line-length measurement with a sticky
// length-mismatch flag.
module scl_ctrl #(
    parameter int PIPE_LAT = 5,
    parameter int LINE_W   = 12
) (
    input  logic       clk_scl,
    input  logic       rst_n_scl,
    scl_ctrl_if.slave  bus
);

    localparam logic [LINE_W-1:0] CNT_MAX = '1;

    // Frame start / shadow configuration
    logic              r_vsync_q;
    logic              w_frame_start;
    logic              r_act_mode;
    logic              r_act_rsz;
    logic [1:0]        r_act_flt;
    logic              r_cfg_upd;

    // Latency-matching delay lines
    logic [PIPE_LAT-1:0] r_en_dly;
    logic [PIPE_LAT:0]   r_hs_dly;
    logic [PIPE_LAT:0]   r_vs_dly;
    logic                w_dp_en;

    // Decimation
    logic [1:0]        r_phase;
    logic              w_keep;
    logic              w_phase_last;
    logic              r_out_en;
    logic              r_out_win;
    logic              r_out_win_q;

    // Line counters and length check
    logic              r_en_q;
    logic              w_in_fall;
    logic              w_out_close;
    logic [LINE_W-1:0] r_in_cnt;
    logic [LINE_W-1:0] r_line_in;
    logic [LINE_W-1:0] r_out_cnt;
    logic [LINE_W-1:0] r_line_out;
    logic [LINE_W-1:0] r_ref_len;
    logic              r_ref_vld;
    logic              r_err_len;

    assign w_frame_start = bus.scl_i_vsync & ~r_vsync_q;
    assign w_dp_en       = r_en_dly[PIPE_LAT-1];
    assign w_in_fall     = r_en_q & ~bus.scl_i_data_en;
    // An output line ends when the latency-matched input window closes, so
    // dropped pixels inside a line do not split it into several runs.
    assign w_out_close   = r_out_win_q & ~r_out_win;

    // Detect vsync rise and load the shadow configuration once per frame
    always_ff @(posedge clk_scl or negedge rst_n_scl) begin
        if (!rst_n_scl) begin
            r_vsync_q  <= 1'b0;
            r_cfg_upd  <= 1'b0;
            r_act_mode <= 1'b0;
            r_act_rsz  <= 1'b0;
            r_act_flt  <= 2'd0;
        end else begin
            r_vsync_q <= bus.scl_i_vsync;
            r_cfg_upd <= w_frame_start;
            if (w_frame_start) begin
                r_act_mode <= bus.scl_cfg_mode;
                r_act_rsz  <= bus.scl_cfg_rsz;
                r_act_flt  <= bus.scl_cfg_flt;
            end
        end
    end

    // Enable delay line: PIPE_LAT stages; syncs get one extra stage so they
    // line up with the registered output enable.
    genvar gi;
    generate
        for (gi = 0; gi < PIPE_LAT; gi++) begin : g_en_dly
            // One stage of the enable delay line
            always_ff @(posedge clk_scl or negedge rst_n_scl) begin
                if (!rst_n_scl) begin
                    r_en_dly[gi] <= 1'b0;
                end else if (gi == 0) begin
                    r_en_dly[gi] <= bus.scl_i_data_en;
                end else begin
                    r_en_dly[gi] <= r_en_dly[(gi == 0) ? 0 : gi-1];
                end
            end
        end

        for (gi = 0; gi <= PIPE_LAT; gi++) begin : g_sync_dly
            // One stage of the hsync/vsync delay lines
            always_ff @(posedge clk_scl or negedge rst_n_scl) begin
                if (!rst_n_scl) begin
                    r_hs_dly[gi] <= 1'b0;
                    r_vs_dly[gi] <= 1'b0;
                end else if (gi == 0) begin
                    r_hs_dly[gi] <= bus.scl_i_hsync;
                    r_vs_dly[gi] <= bus.scl_i_vsync;
                end else begin
                    r_hs_dly[gi] <= r_hs_dly[(gi == 0) ? 0 : gi-1];
                    r_vs_dly[gi] <= r_vs_dly[(gi == 0) ? 0 : gi-1];
                end
            end
        end
    endgenerate

    // Keep decision and phase wrap point for the active ratio
    always_comb begin
        w_keep       = 1'b1;
        w_phase_last = 1'b0;
        if (r_act_rsz) begin
            w_phase_last = (r_phase == 2'd1);
        end else begin
            w_phase_last = (r_phase == 2'd2);
        end
        if (r_act_mode) begin
            if (r_act_rsz) begin
                w_keep = (r_phase == 2'd0);
            end else begin
                w_keep = (r_phase != 2'd2);
            end
        end
    end

    // Phase counter and registered decimated output enable
    always_ff @(posedge clk_scl or negedge rst_n_scl) begin
        if (!rst_n_scl) begin
            r_phase     <= 2'd0;
            r_out_en    <= 1'b0;
            r_out_win   <= 1'b0;
            r_out_win_q <= 1'b0;
        end else begin
            if (!w_dp_en || w_phase_last) begin
                r_phase <= 2'd0;
            end else begin
                r_phase <= r_phase + 2'd1;
            end
            r_out_en    <= w_dp_en & w_keep;
            r_out_win   <= w_dp_en;
            r_out_win_q <= r_out_win;
        end
    end

    // Input line-length counter, reported on the enable falling edge
    always_ff @(posedge clk_scl or negedge rst_n_scl) begin
        if (!rst_n_scl) begin
            r_en_q    <= 1'b0;
            r_in_cnt  <= '0;
            r_line_in <= '0;
        end else begin
            r_en_q <= bus.scl_i_data_en;
            if (w_in_fall) begin
                r_line_in <= r_in_cnt;
                r_in_cnt  <= '0;
            end else if (bus.scl_i_data_en && (r_in_cnt != CNT_MAX)) begin
                r_in_cnt <= r_in_cnt + LINE_W'(1);
            end
        end
    end

    // Output line-length counter: counts kept pixels, reported at line end
    always_ff @(posedge clk_scl or negedge rst_n_scl) begin
        if (!rst_n_scl) begin
            r_out_cnt  <= '0;
            r_line_out <= '0;
        end else begin
            if (w_out_close) begin
                r_line_out <= r_out_cnt;
                r_out_cnt  <= '0;
            end else if (r_out_en && (r_out_cnt != CNT_MAX)) begin
                r_out_cnt <= r_out_cnt + LINE_W'(1);
            end
        end
    end

    // Length check against the first line of the frame; frame start wins
    always_ff @(posedge clk_scl or negedge rst_n_scl) begin
        if (!rst_n_scl) begin
            r_ref_len <= '0;
            r_ref_vld <= 1'b0;
            r_err_len <= 1'b0;
        end else if (w_frame_start) begin
            r_ref_vld <= 1'b0;
            r_err_len <= 1'b0;
        end else if (w_in_fall) begin
            if (!r_ref_vld) begin
                r_ref_len <= r_in_cnt;
                r_ref_vld <= 1'b1;
            end else if (r_in_cnt != r_ref_len) begin
                r_err_len <= 1'b1;
            end
        end
    end

    assign bus.act_mode      = r_act_mode;
    assign bus.act_rsz       = r_act_rsz;
    assign bus.act_flt       = r_act_flt;
    assign bus.cfg_upd       = r_cfg_upd;
    assign bus.dp_en_d       = w_dp_en;
    assign bus.scl_o_data_en = r_out_en;
    assign bus.scl_o_hsync   = r_hs_dly[PIPE_LAT];
    assign bus.scl_o_vsync   = r_vs_dly[PIPE_LAT];
    assign bus.line_in_cnt   = r_line_in;
    assign bus.line_out_cnt  = r_line_out;
    assign bus.err_len       = r_err_len;

endmodule
